// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter.
// FSM state encoding and port indices.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
// last names the port granted most recently; the other wins a tie.
module rr_pick2
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = req0 & (~req1 | (last == P1));
  assign gnt1 = req1 & (~req0 | (last == P0));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with round-robin and bounded lock.
// Grants are combinational; read data returns one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int M        = 16,
  parameter int N        = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic         lock0,
  input  logic         lock1,
  input  logic [M-1:0] addr0,
  input  logic [M-1:0] addr1,
  input  logic [N-1:0] wdata0,
  input  logic [N-1:0] wdata1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic [N-1:0] rdata0,
  output logic [N-1:0] rdata1,
  output logic         mem_w_en,
  output logic [M-1:0] mem_addr,
  output logic [N-1:0] mem_din,
  input  logic [N-1:0] mem_dout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(LOCK_MAX);

  logic [1:0]    state, state_n;
  logic          last, last_n;
  logic [CW-1:0] cnt, cnt_n, inc;
  logic          rr_g0, rr_g1;
  logic          g0, g1, sat;
  logic [1:0]    own;
  logic          oth, lk;
  logic          rv0_q, rv1_q;
  logic [N-1:0]  rd0_q, rd1_q;

  rr_pick2 u_rr (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .gnt0 (rr_g0),
    .gnt1 (rr_g1)
  );

  assign sat = (cnt == CMAX);

  // A saturated owner yields with a dead cycle; the rr pointer then favours the other port.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state)
      ST_OWN0: g0 = req0 & ~(sat & req1);
      ST_OWN1: g1 = req1 & ~(sat & req0);
      default: begin
        g0 = rr_g0;
        g1 = rr_g1;
      end
    endcase
  end

  always_comb begin
    state_n = ST_IDLE;
    cnt_n   = '0;
    last_n  = last;
    own     = g1 ? ST_OWN1 : ST_OWN0;
    oth     = g1 ? req0 : req1;
    lk      = g1 ? lock1 : lock0;
    inc     = CW'(1);
    if (state == own)
      inc = sat ? cnt : cnt + CW'(1);
    if (g0 | g1) begin
      last_n = g1 ? P1 : P0;
      if (lk && !(inc == CMAX && oth)) begin
        state_n = own;
        cnt_n   = inc;
      end
    end
  end

  assign gnt0     = g0 & ~rst;
  assign gnt1     = g1 & ~rst;
  assign mem_w_en = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
  assign mem_din  = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= P1;
      cnt   <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
      rv0_q <= gnt0 & ~we0;
      rv1_q <= gnt1 & ~we1;
      if (gnt0 & ~we0) rd0_q <= mem_dout;
      if (gnt1 & ~we1) rd1_q <= mem_dout;
    end
  end

  assign rvalid0 = rv0_q & ~rst;
  assign rvalid1 = rv1_q & ~rst;
  assign rdata0  = rst ? '0 : rd0_q;
  assign rdata1  = rst ? '0 : rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus read-data scoreboard.
// A small memory array stands in for Data_Memory.
module tb_dmem_arbiter;

  localparam int M = 16;
  localparam int N = 32;

  typedef struct {
    logic rst;
    logic r0, w0, l0;
    logic [M-1:0] a0;
    logic [N-1:0] d0;
    logic r1, w1, l1;
    logic [M-1:0] a1;
    logic [N-1:0] d1;
    logic g0, g1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [M-1:0] addr0 = '0, addr1 = '0;
  logic [N-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_w_en;
  logic [N-1:0] rdata0, rdata1, mem_din, mem_dout;
  logic [M-1:0] mem_addr;

  logic [N-1:0] mem [16];
  logic [N-1:0] ref_mem [16];
  logic [N-1:0] q0 [$];
  logic [N-1:0] q1 [$];
  logic pend0 = 0, pend1 = 0;
  int total = 0, bad = 0;
  vec_t tbl [$];

  always #5 clk = ~clk;

  dmem_arbiter #(.M(M), .N(N), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  assign mem_dout = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_w_en) mem[mem_addr[3:0]] <= mem_din;

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rs,
    input logic r0, input logic w0, input logic l0,
    input logic [M-1:0] a0, input logic [N-1:0] d0,
    input logic r1, input logic w1, input logic l1,
    input logic [M-1:0] a1, input logic [N-1:0] d1,
    input logic g0, input logic g1);
    vec_t v;
    v.rst = rs;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic cyc(input vec_t v);
    logic [M-1:0] ea;
    logic [N-1:0] x;
    rst = v.rst;
    req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
    @(negedge clk);
    chk("gnt0", N'(gnt0), N'(v.g0));
    chk("gnt1", N'(gnt1), N'(v.g1));
    chk("mem_w_en", N'(mem_w_en), N'((v.g0 & v.w0) | (v.g1 & v.w1)));
    ea = v.g0 ? v.a0 : v.g1 ? v.a1 : '0;
    chk("mem_addr", N'(mem_addr), N'(ea));
    chk("rvalid0", N'(rvalid0), N'(pend0 & ~v.rst));
    chk("rvalid1", N'(rvalid1), N'(pend1 & ~v.rst));
    if (pend0) begin
      x = q0.pop_front();
      if (!v.rst) chk("rdata0", rdata0, x);
    end
    if (pend1) begin
      x = q1.pop_front();
      if (!v.rst) chk("rdata1", rdata1, x);
    end
    if (v.rst) begin
      chk("rst_rdata0", rdata0, '0);
      chk("rst_rdata1", rdata1, '0);
    end
    pend0 = v.g0 & ~v.w0;
    pend1 = v.g1 & ~v.w1;
    if (pend0) q0.push_back(ref_mem[v.a0[3:0]]);
    if (pend1) q1.push_back(ref_mem[v.a1[3:0]]);
    if (v.g0 & v.w0) ref_mem[v.a0[3:0]] = v.d0;
    if (v.g1 & v.w1) ref_mem[v.a1[3:0]] = v.d1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    // reset, idle, tie alternation
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(0, 1,0,0,0,0, 1,0,0,1,0, 1,0));
    tbl.push_back(mk(0, 1,0,0,0,0, 1,0,0,1,0, 0,1));
    tbl.push_back(mk(0, 1,0,0,0,0, 1,0,0,1,0, 1,0));
    tbl.push_back(mk(0, 1,0,0,0,0, 1,0,0,1,0, 0,1));
    // single write then read back
    tbl.push_back(mk(0, 1,1,0,0,4, 0,0,0,0,0, 1,0));
    tbl.push_back(mk(0, 1,0,0,0,0, 0,0,0,0,0, 1,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 1,1,0,2,32'h22, 0,1));
    tbl.push_back(mk(0, 1,0,0,0,0, 0,0,0,0,0, 1,0));
    // lock1 against held req0: four grants, then port 0
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1,0,0,0,0, 1,0,1,2,0, 0,1));
    tbl.push_back(mk(0, 1,0,0,0,0, 1,0,1,2,0, 1,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    // uncontended lock past LOCK_MAX, then forced yield
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 0,0,0,0,0, 1,0,1,2,0, 0,1));
    tbl.push_back(mk(0, 1,0,0,0,0, 1,0,1,2,0, 0,0));
    tbl.push_back(mk(0, 1,0,0,0,0, 1,0,1,2,0, 1,0));
    tbl.push_back(mk(0, 1,0,0,0,0, 1,0,1,2,0, 0,1));
    tbl.push_back(mk(0, 1,0,0,0,0, 1,0,0,2,0, 0,1));
    tbl.push_back(mk(0, 1,0,0,0,0, 0,0,0,0,0, 1,0));
    // locked read then write on port 0, port 1 waits
    tbl.push_back(mk(0, 1,1,0,1,32'h11, 0,0,0,0,0, 1,0));
    tbl.push_back(mk(0, 1,0,1,1,0, 0,0,0,0,0, 1,0));
    tbl.push_back(mk(0, 1,1,0,1,6, 1,0,0,1,0, 1,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 1,0,0,1,0, 0,1));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    foreach (tbl[i]) cyc(tbl[i]);

    // reset while port 0 owns the memory with a write pending
    cyc(mk(0, 1,0,1,3,0, 1,0,0,3,0, 1,0));
    cyc(mk(1, 1,1,1,3,32'h99, 1,0,0,3,0, 0,0));
    cyc(mk(0, 1,0,0,3,0, 1,0,0,3,0, 1,0));
    cyc(mk(0, 1,0,0,3,0, 1,0,0,3,0, 0,1));
    cyc(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    chk("mem3_after_rst", mem[3], '0);
    chk("mem1_final", mem[1], 32'h6);
    chk("rdata0_hold", rdata0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
